filler_ctrl: RTL and testbench
==============================

# filler_ctrl

Frame-synchronous controller for the video-path filler stage. It holds CPU-written configuration (enable, fill mode, custom color) in shadow registers and commits them only at a vsync rising edge, so the filler never changes mid-frame. It supervises the input timing: it counts lines per frame, detects vsync loss with a watchdog, and optionally forces black fill on loss. It sits between the SoC register bus and the filler's EN/mode/color inputs, on the video pixel clock.

## Interface
- H_DISP, 12'd1280: active pixels per line (reported only).
- V_DISP, 12'd720: expected active lines per frame.
- VS_TIMEOUT, 24'd2000000: cycles without a vsync rising edge before loss is declared.
- HOLD_FRAMES, 4'd4: vsync edges spent in HOLD after fill is disabled.

- pre_clk  in  1  video pixel clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  register write strobe, one cycle.
- cfg_addr  in  2  register address for read and write.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  read data, registered, 1-cycle latency.
- pre_vs  in  1  input vsync, active high.
- pre_de  in  1  input data enable.
- fill_en  out  1  filler EN.
- fill_mode  out  2  filler mode: 01 black, 10 white, 11 custom.
- fill_color  out  24  filler custom color.
- irq  out  1  one-cycle interrupt pulse.

## Operation
- Registers:
  - 0 CTRL (RW): [0] req_en, [2:1] mode, [3] auto_loss, [4] irq_en.
  - 1 COLOR (RW): [23:0].
  - 2 STATUS (RO): [1:0] state, [2] loss, [3] pending, [4] bad_frame, [31:16] frame_cnt.
  - 3 LINES (RO): [11:0] last_lines.
  - Any write to CTRL or COLOR updates the shadow register and sets pending.
- vs_pe = pre_vs & ~vs_d1, and de_pe = pre_de & ~de_d1, where vs_d1 and de_d1 are 1-cycle registered copies.
- Commit happens on vs_pe while pending=1:
  - active mode/color/auto_loss/irq_en/req_en take the shadow values;
  - pending clears.
- State machine (encoding 00 OFF, 01 ON, 10 HOLD, 11 LOSS):
  - OFF: fill_en=0. A commit with req_en=1 moves to ON.
  - ON: fill_en=1, mode and color from the active registers. A commit with req_en=0 moves to HOLD, and hold_cnt is cleared.
  - HOLD: fill_en=0. Each vs_pe increments hold_cnt. When hold_cnt==HOLD_FRAMES, go to ON if active req_en=1, else OFF. Commits still update the active registers but cause no transition.
  - LOSS: fill_en=1, fill_mode forced to 01, fill_color unchanged. The first vs_pe moves to HOLD (hold_cnt=0) and clears loss.
- Watchdog:
  - 24-bit wd_cnt clears on vs_pe, otherwise increments and saturates at VS_TIMEOUT.
  - When wd_cnt reaches VS_TIMEOUT: loss=1 in any state.
  - If active auto_loss=1 and the state is not LOSS, the state also moves to LOSS.
- Line count:
  - 12-bit line_cnt increments on each de_pe and saturates at 4095.
  - On vs_pe: last_lines<=line_cnt, bad_frame<=(line_cnt!=V_DISP), line_cnt<=0, frame_cnt++ (16-bit, wraps).
  - The first vs_pe after reset also latches, so expect bad_frame=1 then.
- irq pulses for one cycle when active irq_en=1 and either a state transition or a latch with bad_frame=1 occurs; one pulse covers both causes.

## Timing
- Reset values: fill_en=0, fill_mode=01, fill_color=0, irq=0, cfg_rdata=0. All internal registers are 0, state is OFF, and the shadow mode is 01.
- A write is visible on cfg_rdata through a read 2 cycles later (write cycle +1).
- Commit/transition latency: fill_* change on the clock edge at which vs_pe is high, visible in the next cycle.
- A write in the same cycle as vs_pe: the commit uses the old shadow, the new value lands in the shadow, and pending stays 1 for the next frame.
- Priority within one cycle: watchdog loss over commit over hold counting. vs_pe and timeout cannot coincide, because vs_pe clears wd_cnt.
- rst mid-frame: immediate return to reset values; the next vs_pe starts a fresh count.
- cfg_rdata updates every cycle from cfg_addr; writes take no wait states.

## Test plan
- Reset, then write CTRL=0x05 (req_en=1, mode=10), then one vs_pe -> fill_en=1 and fill_mode=10 in the cycle after vs_pe; STATUS state=01 and pending=0; irq pulses once if irq_en=1.
- COLOR=0x123456 and CTRL mode=11 written mid-frame -> fill_color stays 0 until the next vs_pe, then becomes 0x123456; pending reads 1 before the edge and 0 after.
- In ON, write req_en=0 -> fill_en=0 at the next vs_pe; state stays HOLD for exactly 4 further vs_pe; rewriting req_en=1 during HOLD -> ON after the 4th.
- With VS_TIMEOUT=100, auto_loss=1 and no vsync for 100 cycles -> loss=1, state LOSS, fill_en=1, fill_mode=01; the next vs_pe -> HOLD, loss=0.
- A frame with 719 de pulses, then vs_pe -> LINES=719, bad_frame=1, irq pulse; a frame with 720 -> bad_frame=0 and no irq unless the state changes.
- A write coincident with vs_pe -> the old value is committed and the new value is committed one frame later.

Source files
------------

// File: rtl/filler_ctrl_if.sv
// Register-bus port between the SoC CPU side and the filler controller.
interface filler_ctrl_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    modport master (output cfg_we, output cfg_addr, output cfg_wdata, input  cfg_rdata);
    modport slave  (input  cfg_we, input  cfg_addr, input  cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/filler_ctrl.sv
// Frame-synchronous filler controller: shadowed configuration committed on vsync,
// vsync-loss watchdog, per-frame line counting and interrupt generation.
module filler_ctrl #(
    parameter logic [11:0] H_DISP      = 12'd1280,
    parameter logic [11:0] V_DISP      = 12'd720,
    parameter logic [23:0] VS_TIMEOUT  = 24'd2000000,
    parameter logic [3:0]  HOLD_FRAMES = 4'd4
) (
    input  logic         pre_clk,
    input  logic         rst,
    filler_ctrl_if.slave cfg,
    input  logic         pre_vs,
    input  logic         pre_de,
    output logic         fill_en,
    output logic [1:0]   fill_mode,
    output logic [23:0]  fill_color,
    output logic         irq
);
    localparam int unsigned COLOR_W = 24;
    localparam int unsigned LINE_W  = 12;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned WD_W    = 24;
    localparam int unsigned HOLD_W  = 4;

    localparam logic [1:0] ST_OFF  = 2'b00;
    localparam logic [1:0] ST_ON   = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;
    localparam logic [1:0] ST_LOSS = 2'b11;

    localparam logic [1:0] MODE_BLACK = 2'b01;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_COLOR  = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;

    // Field order matches the CTRL register bits [4:0].
    typedef struct packed {
        logic       irq_en;
        logic       auto_loss;
        logic [1:0] mode;
        logic       req_en;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{irq_en: 1'b0, auto_loss: 1'b0, mode: MODE_BLACK, req_en: 1'b0};

    logic [1:0]         state, state_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
    ctrl_t              sh_ctrl, sh_ctrl_n, act_ctrl, act_ctrl_n;
    logic [COLOR_W-1:0] sh_color, sh_color_n, act_color, act_color_n;
    logic               pending, pending_n;
    logic               loss, loss_n;
    logic [WD_W-1:0]    wd_cnt, wd_cnt_n;
    logic [LINE_W-1:0]  line_cnt, line_cnt_n, last_lines, last_lines_n;
    logic               bad_frame, bad_frame_n;
    logic [FRAME_W-1:0] frame_cnt, frame_cnt_n;
    logic               vs_d1, de_d1;
    logic               fill_en_n, irq_n;
    logic [1:0]         fill_mode_n;
    logic [COLOR_W-1:0] fill_color_n;
    logic [31:0]        rdata_n;
    logic               vs_pe, de_pe, timeout, commit;

    logic unused_wdata;
    assign unused_wdata = ^cfg.cfg_wdata[31:24];

    // State and datapath registers.
    always_ff @(posedge pre_clk or posedge rst) begin
        if (rst) begin
            state         <= ST_OFF;
            hold_cnt      <= '0;
            sh_ctrl       <= CTRL_RST;
            act_ctrl      <= '0;
            sh_color      <= '0;
            act_color     <= '0;
            pending       <= 1'b0;
            loss          <= 1'b0;
            wd_cnt        <= '0;
            line_cnt      <= '0;
            last_lines    <= '0;
            bad_frame     <= 1'b0;
            frame_cnt     <= '0;
            vs_d1         <= 1'b0;
            de_d1         <= 1'b0;
            fill_en       <= 1'b0;
            fill_mode     <= MODE_BLACK;
            fill_color    <= '0;
            irq           <= 1'b0;
            cfg.cfg_rdata <= '0;
        end else begin
            state         <= state_n;
            hold_cnt      <= hold_cnt_n;
            sh_ctrl       <= sh_ctrl_n;
            act_ctrl      <= act_ctrl_n;
            sh_color      <= sh_color_n;
            act_color     <= act_color_n;
            pending       <= pending_n;
            loss          <= loss_n;
            wd_cnt        <= wd_cnt_n;
            line_cnt      <= line_cnt_n;
            last_lines    <= last_lines_n;
            bad_frame     <= bad_frame_n;
            frame_cnt     <= frame_cnt_n;
            vs_d1         <= pre_vs;
            de_d1         <= pre_de;
            fill_en       <= fill_en_n;
            fill_mode     <= fill_mode_n;
            fill_color    <= fill_color_n;
            irq           <= irq_n;
            cfg.cfg_rdata <= rdata_n;
        end
    end

    // Next-state, commit, watchdog, line counting and output decode.
    always_comb begin
        state_n      = state;
        hold_cnt_n   = hold_cnt;
        sh_ctrl_n    = sh_ctrl;
        act_ctrl_n   = act_ctrl;
        sh_color_n   = sh_color;
        act_color_n  = act_color;
        pending_n    = pending;
        loss_n       = loss;
        wd_cnt_n     = wd_cnt;
        line_cnt_n   = line_cnt;
        last_lines_n = last_lines;
        bad_frame_n  = bad_frame;
        frame_cnt_n  = frame_cnt;

        vs_pe   = pre_vs & ~vs_d1;
        de_pe   = pre_de & ~de_d1;
        // A vsync edge always wins over a saturated watchdog so LOSS can be left.
        timeout = ~vs_pe & (wd_cnt == VS_TIMEOUT);
        commit  = vs_pe & pending;

        if (vs_pe) begin
            wd_cnt_n = '0;
        end else if (wd_cnt < VS_TIMEOUT) begin
            wd_cnt_n = wd_cnt + WD_W'(1);
        end

        // Commit reads the old shadow; a same-cycle write re-arms pending.
        if (commit) begin
            act_ctrl_n  = sh_ctrl;
            act_color_n = sh_color;
            pending_n   = 1'b0;
        end
        if (cfg.cfg_we && (cfg.cfg_addr == A_CTRL)) begin
            sh_ctrl_n = ctrl_t'(cfg.cfg_wdata[4:0]);
            pending_n = 1'b1;
        end
        if (cfg.cfg_we && (cfg.cfg_addr == A_COLOR)) begin
            sh_color_n = cfg.cfg_wdata[COLOR_W-1:0];
            pending_n  = 1'b1;
        end

        if (timeout) begin
            loss_n = 1'b1;
            if (act_ctrl.auto_loss && (state != ST_LOSS)) begin
                state_n = ST_LOSS;
            end
        end else if (vs_pe) begin
            loss_n = 1'b0;
            case (state)
                ST_OFF: begin
                    if (commit && sh_ctrl.req_en) begin
                        state_n = ST_ON;
                    end
                end
                ST_ON: begin
                    if (commit && !sh_ctrl.req_en) begin
                        state_n    = ST_HOLD;
                        hold_cnt_n = '0;
                    end
                end
                ST_HOLD: begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                    if (({1'b0, hold_cnt} + 5'd1) == {1'b0, HOLD_FRAMES}) begin
                        state_n = act_ctrl_n.req_en ? ST_ON : ST_OFF;
                    end
                end
                default: begin
                    state_n    = ST_HOLD;
                    hold_cnt_n = '0;
                end
            endcase
        end

        if (vs_pe) begin
            last_lines_n = line_cnt;
            bad_frame_n  = (line_cnt != V_DISP);
            line_cnt_n   = '0;
            frame_cnt_n  = frame_cnt + FRAME_W'(1);
        end else if (de_pe && (line_cnt != '1)) begin
            line_cnt_n = line_cnt + LINE_W'(1);
        end

        fill_en_n    = (state_n == ST_ON) || (state_n == ST_LOSS);
        fill_mode_n  = (state_n == ST_ON) ? act_ctrl_n.mode : MODE_BLACK;
        fill_color_n = (state_n == ST_LOSS) ? fill_color : act_color_n;
        irq_n        = act_ctrl_n.irq_en &
                       ((state_n != state) | (vs_pe & (line_cnt != V_DISP)));

        case (cfg.cfg_addr)
            A_CTRL:   rdata_n = {27'd0, sh_ctrl};
            A_COLOR:  rdata_n = {8'd0, sh_color};
            A_STATUS: rdata_n = {frame_cnt, 11'd0, bad_frame, pending, loss, state};
            default:  rdata_n = {4'd0, H_DISP, 4'd0, last_lines};
        endcase
    end
endmodule

// File: tb/tb_filler_ctrl.sv
// Directed and randomized bench for filler_ctrl against a frame-level reference model.
module tb_filler_ctrl;
    localparam logic [11:0] V_DISP      = 12'd24;
    localparam logic [23:0] VS_TIMEOUT  = 24'd100;
    localparam logic [3:0]  HOLD_FRAMES = 4'd4;

    logic        pre_clk = 1'b0;
    logic        rst;
    logic        pre_vs, pre_de;
    logic        fill_en, irq;
    logic [1:0]  fill_mode;
    logic [23:0] fill_color;

    filler_ctrl_if cfg_bus();

    filler_ctrl #(.V_DISP(V_DISP), .VS_TIMEOUT(VS_TIMEOUT), .HOLD_FRAMES(HOLD_FRAMES)) dut (
        .pre_clk(pre_clk), .rst(rst), .cfg(cfg_bus), .pre_vs(pre_vs), .pre_de(pre_de),
        .fill_en(fill_en), .fill_mode(fill_mode), .fill_color(fill_color), .irq(irq)
    );

    always #5 pre_clk = ~pre_clk;

    int irq_cnt = 0;
    always @(negedge pre_clk) if (irq === 1'b1) irq_cnt++;

    int errors = 0;
    int checks = 0;

    // Reference model, updated per register write / vsync edge / timeout event.
    int          m_state, m_hold, exp_irq;
    logic [4:0]  m_sh, m_act;        // [0] req_en [2:1] mode [3] auto_loss [4] irq_en
    logic [23:0] m_sh_color, m_act_color, m_fill_color;
    logic        m_pending, m_loss, m_bad;
    logic [15:0] m_frame;
    logic [11:0] m_last;

    task automatic model_reset();
        m_state = 0; m_hold = 0; m_sh = 5'b00010; m_act = '0;
        m_sh_color = '0; m_act_color = '0; m_fill_color = '0;
        m_pending = 0; m_loss = 0; m_bad = 0; m_frame = '0; m_last = '0;
    endtask

    task automatic model_write(input logic [1:0] a, input logic [31:0] d);
        if (a == 2'd0) begin m_sh = d[4:0]; m_pending = 1; end
        if (a == 2'd1) begin m_sh_color = d[23:0]; m_pending = 1; end
    endtask

    task automatic model_vsync(input int lines);
        int prev;
        bit committed, bad;
        prev = m_state; committed = 0; bad = (lines != int'(V_DISP));
        if (m_pending) begin
            m_act = m_sh; m_act_color = m_sh_color; m_pending = 0; committed = 1;
        end
        case (m_state)
            0: if (committed && m_act[0]) m_state = 1;
            1: if (committed && !m_act[0]) begin m_state = 2; m_hold = 0; end
            2: begin
                m_hold++;
                if (m_hold == int'(HOLD_FRAMES)) m_state = m_act[0] ? 1 : 0;
            end
            default: begin m_state = 2; m_hold = 0; end
        endcase
        m_loss = 0; m_last = 12'(lines); m_bad = bad; m_frame++;
        if (m_act[4] && (m_state != prev || bad)) exp_irq++;
        if (m_state != 3) m_fill_color = m_act_color;
    endtask

    task automatic model_timeout();
        m_loss = 1;
        if (m_act[3] && m_state != 3) begin
            m_state = 3;
            if (m_act[4]) exp_irq++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pre_clk); #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = a; cfg_bus.cfg_wdata = d;
        tick();
        cfg_bus.cfg_we = 1'b0;
        model_write(a, d);
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] r);
        cfg_bus.cfg_addr = a;
        tick();
        r = cfg_bus.cfg_rdata;
    endtask

    task automatic de_pulse();
        pre_de = 1'b1; tick(); pre_de = 1'b0; tick();
    endtask

    task automatic vsync(input int lines);
        pre_vs = 1'b1; tick(); model_vsync(lines); tick(); pre_vs = 1'b0; tick();
    endtask

    task automatic vsync_wr(input int lines, input logic [1:0] a, input logic [31:0] d);
        pre_vs = 1'b1; cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = a; cfg_bus.cfg_wdata = d;
        tick();
        cfg_bus.cfg_we = 1'b0;
        model_vsync(lines); model_write(a, d);
        tick(); pre_vs = 1'b0; tick();
    endtask

    task automatic frame(input int lines);
        for (int i = 0; i < lines; i++) de_pulse();
        vsync(lines);
    endtask

    task automatic check_all(input string tag);
        logic [31:0] r;
        logic        exp_en;
        exp_en = (m_state == 1) || (m_state == 3);
        chk({tag, ".fill_en"}, 32'(fill_en), 32'(exp_en));
        if (exp_en) chk({tag, ".fill_mode"}, 32'(fill_mode), 32'((m_state == 3) ? 2'b01 : m_act[2:1]));
        chk({tag, ".fill_color"}, 32'(fill_color), 32'(m_fill_color));
        chk({tag, ".irq_count"}, 32'(irq_cnt), 32'(exp_irq));
        cfg_read(2'd2, r);
        chk({tag, ".status"}, r, {m_frame, 11'd0, m_bad, m_pending, m_loss, 2'(m_state)});
        cfg_read(2'd3, r);
        chk({tag, ".lines"}, 32'(r[11:0]), 32'(m_last));
    endtask

    initial begin
        logic [31:0] r;
        int          lines;
        exp_irq = 0;
        model_reset();
        rst = 1'b1; pre_vs = 1'b0; pre_de = 1'b0;
        cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = 2'd0; cfg_bus.cfg_wdata = '0;
        repeat (3) @(posedge pre_clk);
        #1 rst = 1'b0;

        chk("rst.fill_en", 32'(fill_en), 32'd0);
        chk("rst.fill_mode", 32'(fill_mode), 32'd1);
        chk("rst.fill_color", 32'(fill_color), 32'd0);
        chk("rst.irq", 32'(irq), 32'd0);
        chk("rst.rdata", cfg_bus.cfg_rdata, 32'd0);
        cfg_read(2'd0, r);
        chk("rst.ctrl", r, 32'h2);
        check_all("rst");

        // Enable white fill with interrupts.
        cfg_write(2'd0, 32'h15);
        cfg_read(2'd0, r);
        chk("wr.ctrl_readback", r, 32'h15);
        check_all("en.pre");
        frame(int'(V_DISP));
        check_all("en.post");

        // Mid-frame color/mode writes stay in the shadow until vsync.
        cfg_write(2'd1, 32'h0012_3456);
        cfg_write(2'd0, 32'h17);
        for (int i = 0; i < 5; i++) de_pulse();
        check_all("color.mid");
        for (int i = 5; i < int'(V_DISP); i++) de_pulse();
        vsync(int'(V_DISP));
        check_all("color.post");

        // Disable, then re-enable during HOLD.
        cfg_write(2'd0, 32'h14);
        frame(int'(V_DISP));
        check_all("hold.enter");
        frame(0);
        check_all("hold.1");
        cfg_write(2'd0, 32'h17);
        for (int k = 2; k <= 4; k++) begin
            frame(int'(V_DISP));
            check_all($sformatf("hold.%0d", k));
        end

        // Watchdog with auto_loss.
        cfg_write(2'd0, 32'h1F);
        frame(int'(V_DISP));
        check_all("loss.armed");
        repeat (40) tick();
        check_all("loss.before");
        repeat (80) tick();
        model_timeout();
        check_all("loss.after");
        vsync(0);
        check_all("loss.exit");
        for (int k = 1; k <= 4; k++) begin
            frame(int'(V_DISP));
            check_all($sformatf("loss.hold%0d", k));
        end

        // Short frame vs nominal frame.
        frame(int'(V_DISP) - 1);
        check_all("lines.short");
        frame(int'(V_DISP));
        check_all("lines.nominal");

        // Write coincident with vsync.
        cfg_write(2'd0, 32'h13);
        for (int i = 0; i < int'(V_DISP); i++) de_pulse();
        vsync_wr(int'(V_DISP), 2'd0, 32'h15);
        check_all("coinc.old");
        frame(int'(V_DISP));
        check_all("coinc.new");

        // Reset in the middle of a frame.
        for (int i = 0; i < 7; i++) de_pulse();
        rst = 1'b1;
        #1;
        chk("mrst.fill_en", 32'(fill_en), 32'd0);
        chk("mrst.fill_mode", 32'(fill_mode), 32'd1);
        chk("mrst.rdata", cfg_bus.cfg_rdata, 32'd0);
        tick();
        rst = 1'b0;
        model_reset();
        frame(3);
        check_all("mrst.frame");

        // Randomized register traffic and frame lengths.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(1, 0) == 1) cfg_write(2'd0, 32'($urandom_range(31, 0)));
            if ($urandom_range(3, 0) == 0) cfg_write(2'd1, $urandom & 32'h00FF_FFFF);
            lines = int'($urandom_range(int'(V_DISP) + 1, 0));
            if ($urandom_range(3, 0) == 0) lines = int'(V_DISP);
            for (int i = 0; i < lines; i++) de_pulse();
            if ($urandom_range(4, 0) == 0)
                vsync_wr(lines, 2'($urandom_range(1, 0)), 32'($urandom_range(31, 0)));
            else
                vsync(lines);
            check_all($sformatf("rand.%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
